// File: rtl/i2c_target_regfile.sv
// I2C target with a pointer-addressed byte register file, matched on a fixed 7-bit address.
// SCL/SDA are oversampled on clk_i; the target never stretches the clock.
module i2c_target_regfile #(
  parameter logic [6:0] I2C_ADDR  = 7'h22,
  parameter int         MEM_DEPTH = 16,
  parameter int         PTR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 scl_i,
  input  logic                 sda_i,
  output logic                 scl_o,
  output logic                 sda_o,
  output logic                 busy_o,
  output logic                 sel_o,
  output logic                 wr_stb_o,
  output logic [PTR_WIDTH-1:0] wr_ptr_o,
  output logic [7:0]           wr_data_o,
  output logic                 rd_stb_o
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_PTR,
    ST_PTR_ACK,
    ST_WR_DATA,
    ST_DATA_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 scl_p0, scl_p1, scl_p2;
  logic                 sda_p0, sda_p1, sda_p2;
  logic                 scl_rise, scl_fall;
  logic                 start_det, stop_det;
  logic [2:0]           bit_cnt;
  logic                 bit_done;
  logic                 byte_rx;
  logic                 ack_on;
  logic                 rw;
  logic                 addr_hit;
  logic                 shifting;
  logic                 in_ack;
  logic [7:0]           rx_sh;
  logic [7:0]           rx_byte;
  logic [7:0]           tx_sh;
  logic [PTR_WIDTH-1:0] ptr;
  logic [PTR_WIDTH-1:0] ptr_inc;
  logic [7:0]           mem [MEM_DEPTH];

  assign scl_o = 1'b1;

  // p0/p1: two-flop synchronizer, p2: previous value for edge detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      scl_p2 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
      sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= scl_i;
      scl_p1 <= scl_p0;
      scl_p2 <= scl_p1;
      sda_p0 <= sda_i;
      sda_p1 <= sda_p0;
      sda_p2 <= sda_p1;
    end
  end

  // Bus events decoded from p1/p2; the registered reaction lands on the next edge
  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;

  assign rx_byte  = {rx_sh[6:0], sda_p1};
  assign bit_done = (bit_cnt == 3'd7);
  assign byte_rx  = scl_rise & bit_done;
  assign addr_hit = (rx_byte[7:1] == I2C_ADDR);
  assign ptr_inc  = ptr + 1'b1;
  assign shifting = (state == ST_ADDR) || (state == ST_WR_PTR) ||
                    (state == ST_WR_DATA) || (state == ST_RD_DATA);
  assign in_ack   = (state == ST_ADDR_ACK) || (state == ST_PTR_ACK) ||
                    (state == ST_DATA_ACK);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ADDR: begin
        if (byte_rx) state_nxt = addr_hit ? ST_ADDR_ACK : ST_IGNORE;
      end
      ST_ADDR_ACK: begin
        if (scl_fall && ack_on) state_nxt = rw ? ST_RD_DATA : ST_WR_PTR;
      end
      ST_WR_PTR: begin
        if (byte_rx) state_nxt = ST_PTR_ACK;
      end
      ST_PTR_ACK: begin
        if (scl_fall && ack_on) state_nxt = ST_WR_DATA;
      end
      ST_WR_DATA: begin
        if (byte_rx) state_nxt = ST_DATA_ACK;
      end
      ST_DATA_ACK: begin
        if (scl_fall && ack_on) state_nxt = ST_WR_DATA;
      end
      ST_RD_DATA: begin
        if (byte_rx) state_nxt = ST_RD_ACK;
      end
      ST_RD_ACK: begin
        if (scl_rise) state_nxt = sda_p1 ? ST_IGNORE : ST_RD_DATA;
      end
      default: state_nxt = state;
    endcase
    // START and STOP override whatever the byte engine was doing
    if (start_det)     state_nxt = ST_ADDR;
    else if (stop_det) state_nxt = ST_IDLE;
  end

  // Control path: state, SDA drive, strobes, pointer and register file
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      sda_o    <= 1'b1;
      busy_o   <= 1'b0;
      sel_o    <= 1'b0;
      wr_stb_o <= 1'b0;
      rd_stb_o <= 1'b0;
      bit_cnt  <= 3'd0;
      ack_on   <= 1'b0;
      rw       <= 1'b0;
      ptr      <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      state    <= state_nxt;
      wr_stb_o <= 1'b0;
      rd_stb_o <= 1'b0;
      if (start_det || stop_det) begin
        busy_o  <= start_det;
        sel_o   <= 1'b0;
        sda_o   <= 1'b1;
        bit_cnt <= 3'd0;
        ack_on  <= 1'b0;
      end else begin
        if (scl_rise && shifting) bit_cnt <= bit_cnt + 3'd1;
        // Ack slot spans two SCL falls: the first pulls SDA low, the second ends it
        if (in_ack && scl_fall) begin
          if (!ack_on) begin
            sda_o  <= 1'b0;
            ack_on <= 1'b1;
          end else begin
            ack_on <= 1'b0;
            if (state == ST_ADDR_ACK && rw) begin
              sda_o    <= mem[ptr][7];
              rd_stb_o <= 1'b1;
            end else begin
              sda_o <= 1'b1;
            end
          end
        end
        case (state)
          ST_ADDR: begin
            if (byte_rx && addr_hit) begin
              sel_o <= 1'b1;
              rw    <= rx_byte[0];
            end
          end
          ST_WR_PTR: begin
            if (byte_rx) ptr <= rx_byte[PTR_WIDTH-1:0];
          end
          ST_WR_DATA: begin
            if (byte_rx) begin
              mem[ptr] <= rx_byte;
              wr_stb_o <= 1'b1;
              ptr      <= ptr_inc;
            end
          end
          ST_RD_DATA: begin
            if (scl_fall) sda_o <= tx_sh[7];
          end
          ST_RD_ACK: begin
            if (scl_fall) sda_o <= 1'b1;
            if (scl_rise) begin
              ptr <= ptr_inc;
              if (!sda_p1) rd_stb_o <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Data path: shift registers and write-strobe payload carry no reset
  always_ff @(posedge clk_i) begin
    if (scl_rise && shifting) rx_sh <= rx_byte;
    if (state == ST_WR_DATA && byte_rx) begin
      wr_ptr_o  <= ptr;
      wr_data_o <= rx_byte;
    end
    if (state == ST_ADDR_ACK && scl_fall && ack_on && rw)
      tx_sh <= {mem[ptr][6:0], 1'b0};
    else if (state == ST_RD_DATA && scl_fall)
      tx_sh <= {tx_sh[6:0], 1'b0};
    else if (state == ST_RD_ACK && scl_rise && !sda_p1)
      tx_sh <= mem[ptr_inc];
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench: an I2C controller model drives the target and checks ACKs, read data and strobes.
module tb_i2c_target_regfile;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_c;
  logic       sda_c;
  logic       sda_bus;
  logic       scl_o, sda_o, busy_o, sel_o, wr_stb_o, rd_stb_o;
  logic [3:0] wr_ptr_o;
  logic [7:0] wr_data_o;

  int         n_cmp = 0;
  int         n_mis = 0;
  int         rd_cnt = 0;
  int         sda_low_cnt = 0;
  logic [7:0] wq_ptr [$];
  logic [7:0] wq_dat [$];

  always #5 clk = ~clk;

  assign sda_bus = sda_c & sda_o;

  i2c_target_regfile #(.I2C_ADDR(7'h22), .MEM_DEPTH(16)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .scl_i     (scl_c & scl_o),
    .sda_i     (sda_bus),
    .scl_o     (scl_o),
    .sda_o     (sda_o),
    .busy_o    (busy_o),
    .sel_o     (sel_o),
    .wr_stb_o  (wr_stb_o),
    .wr_ptr_o  (wr_ptr_o),
    .wr_data_o (wr_data_o),
    .rd_stb_o  (rd_stb_o)
  );

  always @(negedge clk) begin
    if (wr_stb_o) begin
      wq_ptr.push_back({4'h0, wr_ptr_o});
      wq_dat.push_back(wr_data_o);
    end
    if (rd_stb_o) rd_cnt++;
    if (!sda_o) sda_low_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    clks(4);  sda_c = 1'b1;
    clks(6);  scl_c = 1'b1;
    clks(10); sda_c = 1'b0;
    clks(10); scl_c = 1'b0;
  endtask

  task automatic i2c_stop();
    clks(4);  sda_c = 1'b0;
    clks(6);  scl_c = 1'b1;
    clks(10); sda_c = 1'b1;
    clks(10);
  endtask

  task automatic send_bit(input logic b);
    clks(4);  sda_c = b;
    clks(6);  scl_c = 1'b1;
    clks(10); scl_c = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    clks(4); sda_c = 1'b1;
    clks(6); scl_c = 1'b1;
    clks(5); b = sda_bus;
    clks(5); scl_c = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  initial begin
    logic       a;
    logic [7:0] d;
    int         rd0;
    int         low0;
    int         wq0;

    rst = 1'b1; scl_c = 1'b1; sda_c = 1'b1;
    clks(3);
    rst = 1'b0;
    clks(100);
    chk("rst_sda", sda_o, 1);
    chk("rst_scl", scl_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_sel", sel_o, 0);
    chk("rst_wr_stb", wr_stb_o, 0);
    chk("rst_rd_stb", rd_stb_o, 0);
    chk("rst_rd_cnt", rd_cnt, 0);

    // Seed mem[5]=C3 so the pointer left after the read test can be observed
    i2c_start();
    write_byte(8'h44, a); chk("seed_addr_ack", a, 0);
    write_byte(8'h05, a); chk("seed_ptr_ack", a, 0);
    write_byte(8'hC3, a); chk("seed_data_ack", a, 0);
    i2c_stop();
    chk("seed_wr_n", wq_ptr.size(), 1);
    chk("seed_wr_ptr", wq_ptr[0], 8'h05);
    chk("seed_wr_dat", wq_dat[0], 8'hC3);

    // Write 0x03 <- A5, 5A
    i2c_start();
    chk("t1_busy_start", busy_o, 1);
    write_byte(8'h44, a); chk("t1_addr_ack", a, 0);
    chk("t1_sel", sel_o, 1);
    write_byte(8'h03, a); chk("t1_ptr_ack", a, 0);
    write_byte(8'hA5, a); chk("t1_d0_ack", a, 0);
    write_byte(8'h5A, a); chk("t1_d1_ack", a, 0);
    chk("t1_busy_pre_stop", busy_o, 1);
    i2c_stop();
    chk("t1_busy_stop", busy_o, 0);
    chk("t1_sel_stop", sel_o, 0);
    chk("t1_wr_n", wq_ptr.size(), 3);
    chk("t1_wr0_ptr", wq_ptr[1], 8'h03);
    chk("t1_wr0_dat", wq_dat[1], 8'hA5);
    chk("t1_wr1_ptr", wq_ptr[2], 8'h04);
    chk("t1_wr1_dat", wq_dat[2], 8'h5A);

    // Pointer write, repeated START, read two bytes
    rd0 = rd_cnt;
    i2c_start();
    write_byte(8'h44, a); chk("t2_addr_ack", a, 0);
    write_byte(8'h03, a); chk("t2_ptr_ack", a, 0);
    i2c_start();
    chk("t2_rs_busy", busy_o, 1);
    chk("t2_rs_sel", sel_o, 0);
    write_byte(8'h45, a); chk("t2_raddr_ack", a, 0);
    read_byte(d, 1'b0);   chk("t2_rd0", d, 8'hA5);
    read_byte(d, 1'b1);   chk("t2_rd1", d, 8'h5A);
    clks(5);
    chk("t2_nack_release", sda_o, 1);
    i2c_stop();
    chk("t2_rd_stb_n", rd_cnt - rd0, 2);
    chk("t2_no_write", wq_ptr.size(), 3);
    i2c_start();
    write_byte(8'h45, a); chk("t2_ptr5_ack", a, 0);
    read_byte(d, 1'b1);   chk("t2_ptr5_rd", d, 8'hC3);
    i2c_stop();
    chk("t2_rd_stb_n3", rd_cnt - rd0, 3);

    // Pointer wrap at MEM_DEPTH-1
    i2c_start();
    write_byte(8'h44, a); chk("t3_addr_ack", a, 0);
    write_byte(8'h0F, a);
    write_byte(8'h11, a); chk("t3_d0_ack", a, 0);
    write_byte(8'h22, a); chk("t3_d1_ack", a, 0);
    i2c_stop();
    chk("t3_wr_n", wq_ptr.size(), 5);
    chk("t3_wr0_ptr", wq_ptr[3], 8'h0F);
    chk("t3_wr0_dat", wq_dat[3], 8'h11);
    chk("t3_wr1_ptr", wq_ptr[4], 8'h00);
    chk("t3_wr1_dat", wq_dat[4], 8'h22);
    i2c_start();
    write_byte(8'h44, a);
    write_byte(8'h0F, a);
    i2c_start();
    write_byte(8'h45, a); chk("t3_raddr_ack", a, 0);
    read_byte(d, 1'b0);   chk("t3_rd15", d, 8'h11);
    read_byte(d, 1'b1);   chk("t3_rd0", d, 8'h22);
    i2c_stop();

    // Foreign address 0x23 must be ignored entirely
    low0 = sda_low_cnt;
    wq0  = wq_ptr.size();
    i2c_start();
    write_byte(8'h46, a); chk("t4_addr_nack", a, 1);
    chk("t4_sel", sel_o, 0);
    write_byte(8'h12, a); chk("t4_d0_nack", a, 1);
    write_byte(8'h34, a); chk("t4_d1_nack", a, 1);
    i2c_stop();
    chk("t4_sda_never_low", sda_low_cnt - low0, 0);
    chk("t4_no_write", wq_ptr.size(), wq0);

    // Reset while the target drives bit 4 (a 0) of 0xA5
    i2c_start();
    write_byte(8'h44, a);
    write_byte(8'h03, a);
    i2c_start();
    write_byte(8'h45, a); chk("t5_raddr_ack", a, 0);
    recv_bit(a); chk("t5_bit7", a, 1);
    recv_bit(a); chk("t5_bit6", a, 0);
    recv_bit(a); chk("t5_bit5", a, 1);
    clks(5);
    chk("t5_pre_rst_drive", sda_o, 0);
    rst = 1'b1;
    clks(1);
    rst = 1'b0;
    chk("t5_rst_release", sda_o, 1);
    chk("t5_rst_busy", busy_o, 0);
    chk("t5_rst_sel", sel_o, 0);
    i2c_stop();
    i2c_start();
    write_byte(8'h44, a); chk("t5_fresh_ack", a, 0);
    write_byte(8'h03, a); chk("t5_ptr_ack", a, 0);
    i2c_start();
    write_byte(8'h45, a); chk("t5_raddr2_ack", a, 0);
    read_byte(d, 1'b1);   chk("t5_mem_cleared", d, 8'h00);
    i2c_stop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/i2c_target_regfile.md
Name: i2c_target_regfile

Overview:
- Synthesizable I2C target (responder) for the far end of an i2cmb bus channel.
- Oversamples SCL/SDA on the system clock and matches a fixed 7-bit address.
- Implements a pointer-addressed byte register file that the controller can write and read back. Bench use: self-checking loopback against the multi-bus controller without a behavioural slave.
- Clock stretching is not supported.

Parameters:
- I2C_ADDR, 7'h22, target address matched against the first byte after START.
- MEM_DEPTH, 16, register file depth in bytes; must be a power of 2, at least 2 and at most 256.
- PTR_WIDTH, $clog2(MEM_DEPTH), pointer width.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset.
- scl_i  in  1  I2C clock from the bus.
- sda_i  in  1  I2C data from the bus.
- scl_o  out 1  I2C clock drive, open-drain (1 = release); tied to 1.
- sda_o  out 1  I2C data drive, open-drain (1 = release, 0 = pull low).
- busy_o  out 1  high from a START until the next STOP.
- sel_o  out 1  high while this target is addressed.
- wr_stb_o  out 1  one-cycle pulse when a data byte is written to the register file.
- wr_ptr_o  out PTR_WIDTH  register index of the write that pulsed wr_stb_o.
- wr_data_o  out 8  data byte of the write that pulsed wr_stb_o.
- rd_stb_o  out 1  one-cycle pulse when a byte is loaded for transmission.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: sda_o=1, scl_o=1, busy_o=0, sel_o=0, strobes=0, pointer=0, all memory bytes=8'h00, state=IDLE.
- Reset mid-transfer releases SDA on the next clock edge. The target then ignores the bus until a new START.
- Input sampling: two-flop synchronizers on scl_i and sda_i, then a registered previous-value copy for edge detection.
- All bus events act 3 clk_i after the pin change.
- SCL high and SCL low must each last at least 8 clk_i.
- START = SDA falling while SCL high. STOP = SDA rising while SCL high. Both are detected in any state, including a repeated START mid-byte.
- Data bits are sampled on SCL rising edges.
- sda_o changes only on detected SCL falling edges, and only while SCL is low.
- State machine:
  - IDLE: on START, go to ADDR.
  - ADDR: shift 8 bits, MSB first.
    - If the upper 7 bits equal I2C_ADDR: set sel_o, latch R/W, go to ADDR_ACK.
    - Otherwise: go to IGNORE.
  - ADDR_ACK: drive sda_o=0 from the SCL fall after bit 8 until the SCL fall after the ACK bit.
    - If R/W=0: go to WR_PTR.
    - If R/W=1: load mem[ptr], pulse rd_stb_o, drive the MSB on that same SCL fall, go to RD_DATA.
  - WR_PTR: first written byte sets ptr to its low PTR_WIDTH bits; upper bits are ignored. ACK it, then go to WR_DATA.
  - WR_DATA: each byte is written to mem[ptr] on the 8th SCL rise.
    - wr_stb_o pulses on the same clock, with wr_ptr_o/wr_data_o valid that cycle.
    - ptr increments and wraps MEM_DEPTH-1 to 0. ACK the byte, then stay in WR_DATA.
  - RD_DATA: shift out 8 bits. SDA is released after bit 8; go to RD_ACK.
  - RD_ACK: sample SDA on the SCL rise.
    - ACK (0): ptr increments with wrap, the next byte loads with a rd_stb_o pulse, return to RD_DATA.
    - NACK (1): ptr still increments, go to IGNORE with SDA released.
  - IGNORE: SDA released; wait for START (to ADDR) or STOP (to IDLE).
- STOP in any state: state=IDLE, sel_o=0, busy_o=0, SDA released. Pointer and memory are retained.
- Repeated START in any state: go to ADDR, sel_o=0, busy_o stays 1. Pointer is retained, so write-pointer-then-repeated-START-read works.
- A partial byte (fewer than 8 bits before START/STOP) is discarded and causes no write.
- The target never drives SDA while SCL is high, except holding a value already set during low.

Test Plan:
- Reset then idle bus for 100 clk -> sda_o=1, scl_o=1, busy_o=0, all strobes 0.
- Write addr 0x22, ptr 0x03, data 0xA5, 0x5A, STOP -> address and all 3 bytes ACKed; wr_stb_o pulses twice with (3,0xA5) then (4,0x5A); busy_o falls on STOP.
- Write ptr 0x03, repeated START, read addr 0x22, 2 bytes (ACK then NACK) -> target returns 0xA5, 0x5A; rd_stb_o pulses 2x; final ptr=5; SDA released after NACK.
- Write ptr 0x0F, data 0x11, 0x22 (MEM_DEPTH=16) -> mem[15]=0x11, mem[0]=0x22; wrap verified by read-back from ptr 0x0F.
- Address 0x23 write with 2 data bytes -> all 9th bits NACK (sda_o=1 throughout), sel_o=0, no wr_stb_o.
- rst_i asserted for 1 clk during bit 4 of a read byte -> sda_o=1 next cycle, memory=0; a following transaction with a fresh START is ACKed normally.
